// File: rtl/iq_deserializer_pkg.sv
// Shared constants and types for the serial I/Q deserializer.
// Sync words, default sample width, frame-length helper and the lock state enum.
package iq_deserializer_pkg;

    localparam int          IQ_DATA_W = 13;
    localparam logic [1:0]  I_SYNC    = 2'b10;
    localparam logic [1:0]  Q_SYNC    = 2'b01;

    // Each half-frame is sync(2) + sample(w) + ctrl(1).
    function automatic int frame_len(input int w);
        return 2 * (w + 3);
    endfunction

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/iq_deserializer.sv
// Serial I/Q frame deserializer: hunts for the I/Q sync pair, then tracks frame
// boundaries with a bit counter and publishes one I/Q sample per good frame.
module iq_deserializer
    import iq_deserializer_pkg::*;
#(
    parameter int DATA_W   = IQ_DATA_W,
    parameter int MISS_MAX = 2
) (
    input  logic              top_clk,
    input  logic              top_rst,
    input  logic              enable,
    input  logic              serial_in,
    output logic [DATA_W-1:0] iq_i,
    output logic [DATA_W-1:0] iq_q,
    output logic              iq_valid,
    output logic              locked,
    output logic              sync_err,
    output logic [7:0]        err_cnt
);

    localparam int FRAME_W = frame_len(DATA_W);
    localparam int HALF_W  = FRAME_W / 2;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int MISS_W  = (MISS_MAX < 1) ? 1 : $clog2(MISS_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'((MISS_MAX < 1) ? 0 : MISS_MAX - 1);

    // The register keeps the FRAME_W-1 newest bits; the frame's final bit (the
    // Q ctrl bit) is serial_in itself, so every field below is indexed one
    // position lower than in the full frame window.
    logic [FRAME_W-2:0] shift_q;
    logic [FRAME_W-2:0] shift_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [MISS_W-1:0]  miss_q;
    state_t             state_q;
    logic [DATA_W-1:0]  iq_i_q;
    logic [DATA_W-1:0]  iq_q_q;
    logic               iq_valid_q;
    logic               sync_err_q;
    logic [7:0]         err_cnt_q;

    logic               sync_ok;
    logic [DATA_W-1:0]  i_field;
    logic [DATA_W-1:0]  q_field;

    assign shift_d = {shift_q[FRAME_W-3:0], serial_in};
    assign sync_ok = (shift_q[FRAME_W-2 -: 2] == I_SYNC) &&
                     (shift_q[HALF_W-2 -: 2]  == Q_SYNC);
    assign i_field = shift_q[FRAME_W-4 -: DATA_W];
    assign q_field = shift_q[HALF_W-4 -: DATA_W];

    always_ff @(posedge top_clk) begin
        if (!top_rst) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            miss_q     <= '0;
            state_q    <= HUNT;
            iq_i_q     <= '0;
            iq_q_q     <= '0;
            iq_valid_q <= 1'b0;
            sync_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            iq_valid_q <= 1'b0;
            sync_err_q <= 1'b0;
            if (enable) begin
                shift_q <= shift_d;
                case (state_q)
                    HUNT: begin
                        if (sync_ok) begin
                            state_q    <= LOCKED;
                            bit_cnt_q  <= '0;
                            iq_i_q     <= i_field;
                            iq_q_q     <= q_field;
                            iq_valid_q <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (bit_cnt_q == CNT_LAST) begin
                            bit_cnt_q <= '0;
                            if (sync_ok) begin
                                iq_i_q     <= i_field;
                                iq_q_q     <= q_field;
                                iq_valid_q <= 1'b1;
                                miss_q     <= '0;
                            end else begin
                                sync_err_q <= 1'b1;
                                if (err_cnt_q != 8'hFF) begin
                                    err_cnt_q <= err_cnt_q + 8'd1;
                                end
                                // Too many misses in a row: drop lock and re-hunt from scratch.
                                if (miss_q == MISS_LAST) begin
                                    state_q <= HUNT;
                                    miss_q  <= '0;
                                end else begin
                                    miss_q <= miss_q + MISS_W'(1);
                                end
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign iq_i     = iq_i_q;
    assign iq_q     = iq_q_q;
    assign iq_valid = iq_valid_q;
    assign locked   = (state_q == LOCKED);
    assign sync_err = sync_err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_iq_deserializer.sv
// Self-checking bench for iq_deserializer: directed scenarios plus randomized
// frames, compared every cycle against a bit-history reference model.
module tb_iq_deserializer;
    import iq_deserializer_pkg::*;

    localparam int DW = 13;
    localparam int MM = 2;
    localparam int FL = 2 * (DW + 3);
    localparam int HL = FL / 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic          sin   = 1'b0;
    logic [DW-1:0] iq_i;
    logic [DW-1:0] iq_q;
    logic          iq_valid;
    logic          locked;
    logic          sync_err;
    logic [7:0]    err_cnt;

    int total  = 0;
    int bad    = 0;
    int cyc    = 0;
    int vcount = 0;
    int vcyc[$];

    // Reference model state: the received-bit history and the lock bookkeeping.
    bit            hist[$];
    bit            m_locked = 1'b0;
    int            m_since  = 0;
    int            m_miss   = 0;
    int            m_errcnt = 0;
    logic [DW-1:0] m_i      = '0;
    logic [DW-1:0] m_q      = '0;
    bit            m_valid  = 1'b0;
    bit            m_err    = 1'b0;

    iq_deserializer #(.DATA_W(DW), .MISS_MAX(MM)) dut (
        .top_clk  (clk),
        .top_rst  (rst_n),
        .enable   (en),
        .serial_in(sin),
        .iq_i     (iq_i),
        .iq_q     (iq_q),
        .iq_valid (iq_valid),
        .locked   (locked),
        .sync_err (sync_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bit j of the most recent FL bits, j=0 being the oldest (first sent).
    function automatic bit fbit(input int j);
        int idx;
        idx = hist.size() - FL + j;
        return (idx < 0) ? 1'b0 : hist[idx];
    endfunction

    function automatic logic [DW-1:0] field(input int start);
        logic [DW-1:0] v;
        for (int k = 0; k < DW; k++) v[DW-1-k] = fbit(start + k);
        return v;
    endfunction

    function automatic bit frame_ok();
        return fbit(0) && !fbit(1) && !fbit(HL) && fbit(HL + 1);
    endfunction

    task automatic publish();
        m_valid = 1'b1;
        m_i     = field(2);
        m_q     = field(HL + 2);
    endtask

    // Advance the model by one clock using the inputs the DUT will sample next.
    task automatic model_step();
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (rst_n !== 1'b1) begin
            hist.delete();
            m_locked = 1'b0;
            m_since  = 0;
            m_miss   = 0;
            m_errcnt = 0;
            m_i      = '0;
            m_q      = '0;
        end else if (en === 1'b1) begin
            hist.push_back(sin);
            if (hist.size() > FL) void'(hist.pop_front());
            if (!m_locked) begin
                if (frame_ok()) begin
                    m_locked = 1'b1;
                    m_since  = 0;
                    publish();
                end
            end else begin
                m_since = (m_since + 1) % FL;
                if (m_since == 0) begin
                    if (frame_ok()) begin
                        publish();
                        m_miss = 0;
                    end else begin
                        m_err = 1'b1;
                        if (m_errcnt < 255) m_errcnt++;
                        m_miss++;
                        if (m_miss == MM) begin
                            m_locked = 1'b0;
                            m_miss   = 0;
                        end
                    end
                end
            end
        end
    endtask

    // Compare process: outputs settle after posedge, checked on the falling edge.
    initial begin
        bit primed;
        primed = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (primed) begin
                cmp("iq_valid", 32'(iq_valid), 32'(m_valid));
                cmp("sync_err", 32'(sync_err), 32'(m_err));
                cmp("locked",   32'(locked),   32'(m_locked));
                cmp("err_cnt",  32'(err_cnt),  32'(m_errcnt));
                cmp("iq_i",     32'(iq_i),     32'(m_i));
                cmp("iq_q",     32'(iq_q),     32'(m_q));
                if (iq_valid === 1'b1) begin
                    vcount++;
                    vcyc.push_back(cyc);
                end
            end
            model_step();
            primed = 1'b1;
        end
    end

    task automatic drive(input logic b, input logic e);
        @(posedge clk);
        #1;
        sin = b;
        en  = e;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'($urandom), 1'b0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            en    = 1'($urandom);
            sin   = 1'($urandom);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b0;
    endtask

    function automatic logic [FL-1:0] mk_frame(input logic [1:0] is, input logic [DW-1:0] i,
                                                input logic ic, input logic [1:0] qs,
                                                input logic [DW-1:0] q, input logic qc);
        return {is, i, ic, qs, q, qc};
    endfunction

    // Send frame bits lo..hi MSB first, inserting stall_n disabled cycles before bit stall_at.
    task automatic send_vec(input logic [FL-1:0] v, input int lo, input int hi,
                            input int stall_at, input int stall_n);
        for (int j = lo; j <= hi; j++) begin
            if (j == stall_at) repeat (stall_n) drive(1'($urandom), 1'b0);
            drive(v[FL-1-j], 1'b1);
        end
    endtask

    initial begin
        logic [FL-1:0] f;
        logic [FL-1:0] g;
        logic [FL-1:0] b;
        int            vb;
        int            qsig;
        int            r;
        logic [1:0]    is;
        logic [1:0]    qs;

        // Reset state
        do_reset(2);
        cmp("rst_iq_i", 32'(iq_i), 0);
        cmp("rst_iq_q", 32'(iq_q), 0);
        cmp("rst_locked", 32'(locked), 0);
        cmp("rst_err_cnt", 32'(err_cnt), 0);
        cmp("rst_iq_valid", 32'(iq_valid), 0);

        // Three back-to-back frames I=0x0123, Q=0x1F00
        f  = mk_frame(I_SYNC, 13'h0123, 1'b0, Q_SYNC, 13'h1F00, 1'b0);
        vb = vcount;
        repeat (3) send_vec(f, 0, FL - 1, -1, 0);
        idle(2);
        cmp("s1_count", vcount - vb, 3);
        cmp("s1_gap_a", vcyc[$-1] - vcyc[$-2], 32);
        cmp("s1_gap_b", vcyc[$] - vcyc[$-1], 32);
        cmp("s1_iq_i", 32'(iq_i), 32'h0123);
        qsig = int'($signed(iq_q));
        cmp("s1_iq_q_neg256", qsig, -256);
        cmp("s1_locked", 32'(locked), 1);

        // Random prefix bits, then a valid frame
        do_reset(1);
        vb = vcount;
        repeat (5) drive(1'($urandom), 1'b1);
        send_vec(mk_frame(I_SYNC, '0, 1'b0, Q_SYNC, '0, 1'b0), 0, FL - 1, -1, 0);
        idle(2);
        cmp("s2_count", vcount - vb, 1);
        cmp("s2_locked", 32'(locked), 1);
        cmp("s2_err_cnt", 32'(err_cnt), 0);

        // One bad Q sync while locked
        do_reset(1);
        vb = vcount;
        g  = mk_frame(I_SYNC, 13'h0ABC, 1'b0, Q_SYNC, 13'h0456, 1'b0);
        b  = mk_frame(I_SYNC, 13'h0ABC, 1'b0, 2'b11, 13'h0456, 1'b0);
        send_vec(g, 0, FL - 1, -1, 0);
        send_vec(g, 0, FL - 1, -1, 0);
        send_vec(b, 0, FL - 1, -1, 0);
        send_vec(g, 0, FL - 1, -1, 0);
        send_vec(g, 0, FL - 1, -1, 0);
        idle(2);
        cmp("s3_err_cnt", 32'(err_cnt), 1);
        cmp("s3_locked", 32'(locked), 1);
        cmp("s3_count", vcount - vb, 4);
        cmp("s3_iq_i", 32'(iq_i), 32'h0ABC);

        // Two consecutive bad frames drop lock, next good frame relocks
        do_reset(1);
        vb = vcount;
        g  = mk_frame(I_SYNC, '0, 1'b0, Q_SYNC, '0, 1'b0);
        b  = mk_frame(2'b00, '0, 1'b0, 2'b11, '0, 1'b0);
        send_vec(g, 0, FL - 1, -1, 0);
        send_vec(b, 0, FL - 1, -1, 0);
        send_vec(b, 0, FL - 1, -1, 0);
        idle(2);
        cmp("s4_unlocked", 32'(locked), 0);
        cmp("s4_err_cnt", 32'(err_cnt), 2);
        send_vec(g, 0, FL - 1, -1, 0);
        idle(2);
        cmp("s4_relocked", 32'(locked), 1);
        cmp("s4_count", vcount - vb, 2);

        // Seven-cycle enable stall in the middle of a frame
        do_reset(1);
        vb = vcount;
        send_vec(f, 0, FL - 1, -1, 0);
        send_vec(f, 0, FL - 1, 10, 7);
        send_vec(f, 0, FL - 1, -1, 0);
        idle(2);
        cmp("s5_count", vcount - vb, 3);
        cmp("s5_gap_stall", vcyc[$-1] - vcyc[$-2], 39);
        cmp("s5_gap_after", vcyc[$] - vcyc[$-1], 32);

        // Reset at bit 20 of a frame
        do_reset(1);
        send_vec(f, 0, FL - 1, -1, 0);
        send_vec(f, 0, 19, -1, 0);
        do_reset(1);
        cmp("s6_iq_i", 32'(iq_i), 0);
        cmp("s6_iq_q", 32'(iq_q), 0);
        cmp("s6_locked", 32'(locked), 0);
        vb = vcount;
        send_vec(f, 20, FL - 1, -1, 0);
        idle(1);
        cmp("s6_no_partial", vcount - vb, 0);
        send_vec(f, 0, FL - 1, -1, 0);
        idle(2);
        cmp("s6_relock", 32'(locked), 1);
        cmp("s6_count", vcount - vb, 1);
        cmp("s6_iq_i_new", 32'(iq_i), 32'h0123);

        // Randomized traffic: good/corrupt frames, stalls, noise, occasional reset
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                is = ($urandom_range(0, 4) == 0) ? 2'($urandom) : I_SYNC;
                qs = ($urandom_range(0, 4) == 0) ? 2'($urandom) : Q_SYNC;
                f  = mk_frame(is, DW'($urandom), 1'($urandom), qs, DW'($urandom), 1'($urandom));
                send_vec(f, 0, FL - 1, $urandom_range(0, 60), $urandom_range(1, 5));
            end else if (r < 9) begin
                repeat ($urandom_range(1, 20)) drive(1'($urandom), ($urandom_range(0, 4) != 0));
            end else begin
                do_reset(1);
            end
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iq_deserializer.md
IQ_DESERIALIZER -- requirements
Module: iq_deserializer

Interface
REQ-001 Parameter DATA_W, default 13, sample width of I and Q (two's complement).
REQ-002 Parameter MISS_MAX, default 2, consecutive bad sync words tolerated before leaving LOCKED.
REQ-003 Port top_clk  input  1  bit clock; serial_in sampled on rising edge, one bit per cycle.
REQ-004 Port top_rst  input  1  reset, synchronous, active-low.
REQ-005 Port enable  input  1  1 = deserializer runs; 0 = hold state, no shifting, no outputs pulsed.
REQ-006 Port serial_in  input  1  serial I/Q stream from radio, MSB first.
REQ-007 Port iq_i  output  DATA_W  last received I sample.
REQ-008 Port iq_q  output  DATA_W  last received Q sample.
REQ-009 Port iq_valid  output  1  one-cycle pulse, iq_i/iq_q updated this cycle.
REQ-010 Port locked  output  1  1 while in LOCKED state.
REQ-011 Port sync_err  output  1  one-cycle pulse on a bad sync word while LOCKED.
REQ-012 Port err_cnt  output  8  saturating count of sync_err pulses since reset.

Function
REQ-013 Frame SHALL be 2*(DATA_W+3) bits (32 at default): I_SYNC 2'b10, I[DATA_W-1:0], I ctrl bit, Q_SYNC 2'b01, Q[DATA_W-1:0], Q ctrl bit, sent MSB first.
REQ-014 Block SHALL shift serial_in into a frame-width shift register every enabled cycle, newest bit at LSB.
REQ-015 States SHALL be HUNT and LOCKED; reset state HUNT.
REQ-016 HUNT: every enabled cycle the shift register (including the bit just shifted in) SHALL be checked for both I_SYNC and Q_SYNC at their frame positions; on match go to LOCKED, load bit counter 0, publish sample.
REQ-017 LOCKED: bit counter SHALL increment each enabled cycle, wrapping at frame length-1; on the wrap cycle both syncs are checked.
REQ-018 LOCKED good sync: publish sample, clear miss counter.
REQ-019 LOCKED bad sync: pulse sync_err, increment err_cnt (saturate at 255), increment miss counter, no iq_valid; when miss counter reaches MISS_MAX go to HUNT and clear miss counter.
REQ-020 Publish SHALL register iq_i/iq_q from the frame fields and pulse iq_valid in the cycle after the rising edge sampling the frame's last bit (latency 1 cycle).
REQ-021 Ctrl bits SHALL be discarded; syncs SHALL match exactly, no tolerance.
REQ-022 iq_i/iq_q SHALL hold value between publishes.
REQ-023 enable low SHALL freeze shift register, bit counter, state and miss counter; iq_valid and sync_err stay 0; resume exactly where stopped.
REQ-024 In HUNT, a match found on any cycle (including false lock mid-data) SHALL be accepted; recovery relies on REQ-019.
REQ-025 locked SHALL be registered state (1 in LOCKED), changing in the same cycle as the state.

Reset
REQ-026 On top_rst low at a rising edge: state HUNT, shift register 0, bit and miss counters 0, iq_i=0, iq_q=0, iq_valid=0, locked=0, sync_err=0, err_cnt=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; no iq_valid until a full new frame matches.
REQ-028 Reset SHALL dominate enable.

Structure
REQ-029 Shared package SHALL hold I_SYNC, Q_SYNC, default DATA_W, frame-length function and state enum.
REQ-030 Single module; no sub-module required (sync checker inline).

Verification
REQ-031 Reset then 3 frames I=0x0123, Q=0x1F00 -> iq_valid 3 pulses, 32 cycles apart, first 1 cycle after first frame's last bit; iq_i=0x0123, iq_q=-256; locked=1 after first frame.
REQ-032 5 random bits then valid frame -> lock on that frame's end, correct sample, err_cnt=0.
REQ-033 Locked, one frame with Q_SYNC=2'b11 then good frames -> one sync_err, no iq_valid for bad frame, stays locked, err_cnt=1.
REQ-034 Locked, two consecutive bad frames (MISS_MAX=2) -> two sync_err, locked drops after second, relock on next good frame.
REQ-035 enable low 7 cycles mid-frame -> output identical to unstalled stream, delayed 7 cycles.
REQ-036 top_rst low at bit 20 of a frame -> all outputs 0, no iq_valid from remainder, lock on next full frame.
